// File: rtl/audio_pkg.sv
// Shared audio-path types and defaults: sample width, scheduler states, FIFO sizing.
package audio_pkg;

    localparam int SAMPLE_W        = 24;
    localparam int DEFAULT_ADDR_W  = 9;
    localparam int DEFAULT_PREFILL = 256;

    typedef enum logic {
        ST_PREFILL = 1'b0,
        ST_PLAY    = 1'b1
    } play_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO with extra-MSB wrap pointers and RAM-friendly storage.
// Latency: read data registered one cycle after pop; count reflects last cycle's push/pop.
// Backpressure: none internally; caller must not push when full (unless popping) or pop when empty.
module sample_fifo #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_dat,
    output logic [DATA_W-1:0] rd_dat,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // No reset on the array or read register so the storage maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[ADDR_W-1:0]] <= wr_dat;
        if (pop && !flush)  rd_dat <= mem[rd_ptr[ADDR_W-1:0]];
    end

    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/sample_playout_scheduler.sv
// Jitter buffer between UART sample receiver and DAC: prefill, then one sample per request.
// Latency: sample_valid one cycle after sample_req; zero substituted while prefilling or on underrun.
// Backpressure: none; full FIFO drops input (overflow). Optional PLAYOUT_STATS_EN adds event counters.
module sample_playout_scheduler
    import audio_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int PREFILL  = DEFAULT_PREFILL,
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                byte_ready,
    input  logic [SAMPLE_W-1:0] rx_sample,
    input  logic                flush,
    input  logic                sample_req,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                playing,
    output logic [ADDR_W:0]     fill_level,
    output logic                overflow,
    output logic                underrun
`ifdef PLAYOUT_STATS_EN
    ,
    output logic [15:0]         underrun_cnt,
    output logic [15:0]         overflow_cnt
`endif
);

    localparam logic [ADDR_W:0] PREFILL_LVL = (ADDR_W + 1)'(PREFILL);

    play_state_t         state_q;
    play_state_t         state_d;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                drop;
    logic                under_evt;
    logic                zero_q;
    logic [SAMPLE_W-1:0] fifo_rd_dat;

    // flush wins over everything; a full FIFO still accepts a push when the same cycle pops.
    assign pop       = sample_req && !flush && (state_q == ST_PLAY) && !fifo_empty;
    assign under_evt = sample_req && !flush && (state_q == ST_PLAY) && fifo_empty;
    assign push      = byte_ready && !flush && (!fifo_full || pop);
    assign drop      = byte_ready && !flush && fifo_full && !pop;

    sample_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (SAMPLE_W)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .push   (push),
        .pop    (pop),
        .wr_dat (rx_sample),
        .rd_dat (fifo_rd_dat),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fill_level)
    );

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_PREFILL;
        end else begin
            case (state_q)
                ST_PREFILL: if (fill_level >= PREFILL_LVL) state_d = ST_PLAY;
                ST_PLAY:    if (under_evt) state_d = ST_PREFILL;
                default:    state_d = ST_PREFILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_PREFILL;
            sample_valid <= 1'b0;
            zero_q       <= 1'b1;
            overflow     <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_valid <= sample_req;
            if (sample_req) zero_q <= !pop;
            if (flush) begin
                overflow <= 1'b0;
                underrun <= 1'b0;
            end else begin
                if (drop)      overflow <= 1'b1;
                if (under_evt) underrun <= 1'b1;
            end
        end
    end

    // The FIFO read register only moves on a pop, so this mux holds between pulses.
    assign sample_out = zero_q ? '0 : fifo_rd_dat;
    assign playing    = (state_q == ST_PLAY);

`ifdef PLAYOUT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
            overflow_cnt <= '0;
        end else begin
            if (under_evt && (underrun_cnt != 16'hFFFF)) underrun_cnt <= underrun_cnt + 16'd1;
            if (drop && (overflow_cnt != 16'hFFFF))      overflow_cnt <= overflow_cnt + 16'd1;
        end
    end
`endif

endmodule
